// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port among nreq writeback
//   sources (ALU, load unit, mul/div, ...). A round-robin arbiter grants one
//   valid requester per cycle. The accepted write is captured in a registered
//   write stage that drives the register file on the following cycle.
//   Writes to register 0 complete their handshake but are never presented to
//   the register file.
//
// Ports
//   clock       system clock, all state on the rising edge
//   reset       asynchronous active-high reset
//   en          arbiter enable; 0 freezes grants and new writes
//   req_valid   per-requester write pending
//   req_ready   one-hot grant; transfer on valid[i] & ready[i]
//   req_addr    packed destinations, requester i at [i*addr_len +: addr_len]
//   req_data    packed write data, requester i at [i*dtype +: dtype]
//   wr_en       register file clk_en
//   wr_addr     register file rZ_address
//   wr_data     register file rZ
//   pending     per-register flag: write waiting at a requester or in the
//               write stage
//   last_grant  index of the most recently accepted requester
module regfile_wb_arbiter #(
   parameter int dtype    = 16,
   parameter int nregs    = 8,
   parameter int addr_len = $clog2(nregs),
   parameter int nreq     = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      en,
   input  logic [nreq-1:0]           req_valid,
   output logic [nreq-1:0]           req_ready,
   input  logic [nreq*addr_len-1:0]  req_addr,
   input  logic [nreq*dtype-1:0]     req_data,
   output logic                      wr_en,
   output logic [addr_len-1:0]       wr_addr,
   output logic [dtype-1:0]          wr_data,
   output logic [nregs-1:0]          pending,
   output logic [$clog2(nreq)-1:0]   last_grant
);

   localparam int gw = $clog2(nreq);

   logic [gw-1:0]       rr_ptr_q,     rr_ptr_d;
   logic [gw-1:0]       last_grant_q, last_grant_d;
   logic                wr_en_q,      wr_en_d;
   logic [addr_len-1:0] wr_addr_q,    wr_addr_d;
   logic [dtype-1:0]    wr_data_q,    wr_data_d;

   logic [nreq-1:0]     grant_vec;
   logic [gw-1:0]       grant_idx;
   logic                grant_vld;
   logic [addr_len-1:0] sel_addr;
   logic [dtype-1:0]    sel_data;

   // Scan from rr_ptr upward with wrap; the first valid index wins. The
   // grant depends only on req_valid, en and rr_ptr, never on itself.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vec = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      if (en && !reset) begin
         for (int k = 0; k < nreq; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (!grant_vld && req_valid[idx]) begin
               grant_vld      = 1'b1;
               grant_idx      = gw'(idx);
               grant_vec[idx] = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant_vec;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < nreq; i++) begin
         if (grant_vec[i]) begin
            sel_addr = req_addr[i*addr_len +: addr_len];
            sel_data = req_data[i*dtype +: dtype];
         end
      end
   end

   // Idle cycles drop wr_en but hold address/data so the regfile port is
   // quiet. A register-0 destination is consumed with wr_en kept low.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      last_grant_d = last_grant_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      if (grant_vld) begin
         rr_ptr_d     = (grant_idx == gw'(nreq - 1)) ? '0 : grant_idx + 1'b1;
         last_grant_d = grant_idx;
         wr_addr_d    = sel_addr;
         wr_data_d    = sel_data;
         wr_en_d      = (sel_addr != '0);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         last_grant_q <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         last_grant_q <= last_grant_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign last_grant = last_grant_q;

   // Register 0 is never written, so it is never reported as pending.
   always_comb begin
      pending = '0;
      for (int r = 1; r < nregs; r++) begin
         if (wr_en_q && wr_addr_q == addr_len'(r)) pending[r] = 1'b1;
         for (int i = 0; i < nreq; i++) begin
            if (en && req_valid[i] && req_addr[i*addr_len +: addr_len] == addr_len'(r))
               pending[r] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int DW = 16;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam int NQ = 3;

   logic            clock;
   logic            reset;
   logic            en;
   logic [NQ-1:0]   req_valid;
   logic [NQ-1:0]   req_ready;
   logic [NQ*AW-1:0] req_addr;
   logic [NQ*DW-1:0] req_data;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [NR-1:0]   pending;
   logic [1:0]      last_grant;

   int checks = 0;
   int errors = 0;

   logic [AW+DW-1:0] sb[$];

   regfile_wb_arbiter #(.dtype(DW), .nregs(NR), .addr_len(AW), .nreq(NQ)) dut (
      .clock(clock), .reset(reset), .en(en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pending(pending), .last_grant(last_grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // Every write reaching the register file must match the oldest expected one.
   always @(negedge clock) begin
      logic [AW+DW-1:0] e;
      if (!reset && wr_en) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected_write observed=%0h expected=none", {wr_addr, wr_data});
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert ({wr_addr, wr_data} === e) else begin
               errors++;
               $error("FAIL sb_write observed=%0h expected=%0h", {wr_addr, wr_data}, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; en = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", req_ready, 0);
      reset = 1'b0;
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_last_grant", last_grant, 0);
      chk("rst_pending", pending, 0);
      cyc();

      // Round robin over three held requesters
      set_req(0, 3'd1, 16'h0011); set_req(1, 3'd2, 16'h0022); set_req(2, 3'd3, 16'h0033);
      req_valid = 3'b111;
      #1; chk("rr_ready0", req_ready, 3'b001); sb.push_back({3'd1, 16'h0011});
      cyc(); chk("rr_wr_en0", wr_en, 1); chk("rr_lg0", last_grant, 0);
      #1; chk("rr_ready1", req_ready, 3'b010); sb.push_back({3'd2, 16'h0022});
      cyc(); chk("rr_lg1", last_grant, 1);
      #1; chk("rr_ready2", req_ready, 3'b100); sb.push_back({3'd3, 16'h0033});
      cyc(); chk("rr_lg2", last_grant, 2);
      #1; chk("rr_ready3", req_ready, 3'b001); sb.push_back({3'd1, 16'h0011});
      cyc();

      // Single request from requester 1
      req_valid = 3'b010; set_req(1, 3'd5, 16'hBEEF);
      #1; chk("single_ready", req_ready, 3'b010);
      chk("single_pending", pending, 8'b0010_0010);
      sb.push_back({3'd5, 16'hBEEF});
      cyc(); chk("single_wr_en", wr_en, 1); chk("single_wr_addr", wr_addr, 5);
      chk("single_wr_data", wr_data, 16'hBEEF); chk("single_lg", last_grant, 1);
      req_valid = '0;
      #1; chk("single_pend_ws", pending, 8'b0010_0000);
      cyc(); chk("single_wr_en_off", wr_en, 0); chk("single_pend_clr", pending, 0);
      chk("idle_hold_addr", wr_addr, 5); chk("idle_hold_data", wr_data, 16'hBEEF);

      // Write to r0 is consumed but never reaches the register file
      req_valid = 3'b100; set_req(2, 3'd0, 16'hFFFF);
      #1; chk("r0_ready", req_ready, 3'b100); chk("r0_pending", pending, 0);
      cyc(); chk("r0_wr_en", wr_en, 0); chk("r0_lg", last_grant, 2);
      req_valid = 3'b001; set_req(0, 3'd6, 16'h1234);
      #1; chk("prep_ready", req_ready, 3'b001); sb.push_back({3'd6, 16'h1234});
      cyc();

      // Two requesters target r4, pointer at 1
      req_valid = 3'b011; set_req(0, 3'd4, 16'h0A0A); set_req(1, 3'd4, 16'h0B0B);
      #1; chk("conf_ready1", req_ready, 3'b010); chk("conf_pend_a", pending[4], 1);
      sb.push_back({3'd4, 16'h0B0B});
      cyc(); req_valid = 3'b001;
      #1; chk("conf_ready0", req_ready, 3'b001); chk("conf_pend_b", pending[4], 1);
      sb.push_back({3'd4, 16'h0A0A});
      cyc(); req_valid = '0;
      #1; chk("conf_pend_c", pending[4], 1); chk("conf_final_data", wr_data, 16'h0A0A);
      cyc(); chk("conf_pend_clr", pending[4], 0); chk("conf_wr_en_off", wr_en, 0);

      // Freeze with requests held; rr_ptr is 1 here
      set_req(0, 3'd1, 16'h0011); set_req(1, 3'd2, 16'h0022); set_req(2, 3'd3, 16'h0033);
      req_valid = 3'b111;
      #1; chk("frz_pre_ready", req_ready, 3'b010); sb.push_back({3'd2, 16'h0022});
      cyc(); en = 1'b0;
      #1; chk("frz_ready0", req_ready, 0); chk("frz_inflight", wr_en, 1);
      chk("frz_pending", pending, 8'b0000_0100);
      for (int c = 0; c < 3; c++) begin
         cyc(); chk("frz_wr_en", wr_en, 0); chk("frz_ready", req_ready, 0);
      end
      en = 1'b1;
      #1; chk("frz_resume_ready", req_ready, 3'b100); sb.push_back({3'd3, 16'h0033});
      cyc(); chk("frz_resume_wr_en", wr_en, 1); chk("frz_resume_lg", last_grant, 2);

      // Asynchronous reset mid-cycle with a write in the write stage
      @(negedge clock);
      #2; reset = 1'b1;
      #1; chk("arst_wr_en", wr_en, 0); chk("arst_wr_addr", wr_addr, 0);
      chk("arst_wr_data", wr_data, 0); chk("arst_lg", last_grant, 0);
      chk("arst_ready", req_ready, 0);
      cyc(); chk("arst_ready_hold", req_ready, 0); chk("arst_wr_en_hold", wr_en, 0);
      reset = 1'b0;
      #1; chk("arst_first_grant", req_ready, 3'b001); sb.push_back({3'd1, 16'h0011});
      cyc(); req_valid = '0; chk("arst_post_wr_en", wr_en, 1); chk("arst_post_lg", last_grant, 0);
      cyc(); chk("end_wr_en", wr_en, 0);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
